// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StLoad,
        StFlush,
        StCheck,
        StDone,
        StErr
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte packer: gathers little-endian bytes into a 32-bit word and pulses
// word_valid_o on the byte that completes it.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_i,
    input  logic                      byte_en_i,
    input  logic [7:0]                byte_i,
    output logic [8*WORD_BYTES-1:0]   word_o,
    output logic                      word_valid_o
);

    logic [LANE_W-1:0]               lane_q, lane_d;
    logic [8*(WORD_BYTES-1)-1:0]     shift_q, shift_d;

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clr_i) begin
            lane_d  = '0;
            shift_d = '0;
        end else if (byte_en_i) begin
            // Lower lanes shift down; the last lane never needs storing.
            shift_d = {byte_i, shift_q[8*(WORD_BYTES-1)-1:8]};
            lane_d  = lane_q + LANE_W'(1);
        end
    end

    assign word_valid_o = byte_en_i && (lane_q == LANE_W'(WORD_BYTES - 1));
    assign word_o       = {byte_i, shift_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a count-prefixed byte image into instruction memory and holds the core in
// reset until loaded. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned IdxW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                fire;
    logic                pack_clr;
    logic                pack_en;
    logic                word_valid;
    logic [31:0]         word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    assign in_ready = (state_q == StCount) || (state_q == StLoad) || (state_q == StCheck);
    assign fire     = in_valid && in_ready;
    // Clearing throughout COUNT guarantees lane 0 on every entry to LOAD.
    assign pack_clr = (state_q == StCount);
    assign pack_en  = fire && (state_q == StLoad);

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (pack_clr),
        .byte_en_i    (pack_en),
        .byte_i       (in_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StCount;
                    idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            StCount: begin
                if (fire) begin
                    if (in_data == 8'd0 || 32'(in_data) > MAX_WORDS) begin
                        state_d = StErr;
                    end else begin
                        state_d = StLoad;
                        last_d  = IdxW'(in_data - 8'd1);
                    end
                end
            end
            StLoad: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (fire) begin
                    csum_d = csum_q ^ in_data;
                end
`endif
                if (word_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'({idx_q, 2'b00});
                    wr_data_d = word;
                    idx_d     = idx_q + IdxW'(1);
                    if (idx_q == last_q) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = StCheck;
`else
                state_d = StDone;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCheck: begin
                if (fire) begin
                    state_d = (in_data == csum_q) ? StDone : StErr;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            last_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == StCount) || (state_q == StLoad) ||
                     (state_q == StFlush) || (state_q == StCheck);
    assign done    = (state_q == StDone);
    assign err     = (state_q == StErr);
    assign cpu_rst = (state_q != StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed steps plus random images checked
// against an expected write list built from the image words.
module tb_imem_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 64;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]        stream_q[$];
    logic [31:0]       words_q[$];
    logic [ADDR_W-1:0] mon_addr[$];
    logic [31:0]       mon_data[$];

    // Every cycle with wr_en high is one memory write.
    always @(negedge clk) begin
        if (wr_en) begin
            mon_addr.push_back(wr_addr);
            mon_data.push_back(wr_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic rand_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    // Stream = count byte, payload bytes LSB first, optional XOR byte.
    task automatic build(input int n_field, input logic bad_cs);
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'd0;
        stream_q.delete();
        stream_q.push_back(n_field[7:0]);
        foreach (words_q[i]) begin
            w = words_q[i];
            for (int k = 0; k < 4; k++) begin
                stream_q.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (words_q.size() > 0) stream_q.push_back(cs ^ {7'd0, bad_cs});
`else
        if (bad_cs) cs = 8'd0;
`endif
    endtask

    // mode 0: no stalls, 1: valid low every other cycle, 2: random stalls.
    task automatic send(input int mode, input int limit, input int pulse_at);
        int n;
        int waited;
        n = (limit < 0) ? stream_q.size() : limit;
        for (int i = 0; i < n; i++) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = stream_q[i];
            start    = (i == pulse_at);
            waited   = 0;
            while (!in_ready && waited < 50) begin
                @(posedge clk); #1;
                waited++;
            end
            if (waited >= 50) begin
                chk("handshake_timeout", 32'd1, 32'd0);
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwrites"}, 32'(mon_addr.size()), 32'(words_q.size()));
        for (int i = 0; i < words_q.size() && i < mon_addr.size(); i++) begin
            chk({tag, "_addr"}, 32'(mon_addr[i]), (i * 4) % (1 << ADDR_W));
            chk({tag, "_data"}, mon_data[i], words_q[i]);
        end
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic expect_err(input string tag);
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic load_image(input string tag, input int mode, input int pulse_at);
        mon_addr.delete();
        mon_data.delete();
        pulse_start();
        build(words_q.size(), 1'b0);
        send(mode, -1, pulse_at);
        settle();
        check_writes(tag);
        expect_done(tag);
    endtask

    task automatic expect_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        expect_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed image, continuous valid, exact write/release timing.
        mon_addr.delete();
        mon_data.delete();
        words_q = '{32'h0000_0013, 32'h0010_0093};
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_in_ready", 32'(in_ready), 32'd1);
        chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
        build(2, 1'b0);
        send(0, -1, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t_csum_done", 32'(done), 32'd1);
        chk("t_csum_cpu_rst", 32'(cpu_rst), 32'd0);
`else
        chk("t1_wr_en", 32'(wr_en), 32'd1);
        chk("t1_wr_addr", 32'(wr_addr), 32'h04);
        chk("t1_wr_data", wr_data, 32'h0010_0093);
        chk("t1_done", 32'(done), 32'd0);
        chk("t1_cpu_rst", 32'(cpu_rst), 32'd1);
        @(posedge clk); #1;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("t2_wr_en", 32'(wr_en), 32'd0);
`endif
        chk("done_in_ready", 32'(in_ready), 32'd0);
        settle();
        check_writes("direct");

        // Same image with in_valid toggling.
        load_image("toggle", 1, -1);

        // Count byte of zero, then recovery with N=1.
        mon_addr.delete();
        mon_data.delete();
        words_q.delete();
        pulse_start();
        build(0, 1'b0);
        send(0, -1, -1);
        settle();
        expect_err("n0");
        chk("n0_nwrites", 32'(mon_addr.size()), 32'd0);
        rand_words(1);
        load_image("n0_recover", 0, -1);

        // Count byte one above the limit.
        mon_addr.delete();
        mon_data.delete();
        words_q.delete();
        pulse_start();
        build(MAX_WORDS + 1, 1'b0);
        send(0, -1, -1);
        settle();
        expect_err("nmax1");
        chk("nmax1_nwrites", 32'(mon_addr.size()), 32'd0);
        rand_words(1);
        load_image("nmax1_recover", 0, -1);

        // start pulse while a payload byte is handed over.
        rand_words(4);
        load_image("start_in_load", 0, 6);

        // start in DONE re-asserts core reset and reloads from address 0.
        pulse_start();
        chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_busy", 32'(busy), 32'd1);
        mon_addr.delete();
        mon_data.delete();
        rand_words(3);
        build(3, 1'b0);
        send(2, -1, -1);
        settle();
        check_writes("reload");
        expect_done("reload");

        // Asynchronous reset in the middle of a word.
        rand_words(4);
        pulse_start();
        build(4, 1'b0);
        send(0, 3, -1);
        rst_n = 1'b0;
        #1;
        expect_reset_outputs("midreset");
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rand_words(2);
        load_image("after_reset", 0, -1);

        // Random images, the first at the maximum size.
        for (int r = 0; r < 4; r++) begin
            rand_words((r == 0) ? MAX_WORDS : int'($urandom_range(1, 12)));
            load_image("random", 2, -1);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        words_q = '{32'h0804_0201};
        load_image("csum_good", 0, -1);
        mon_addr.delete();
        mon_data.delete();
        pulse_start();
        build(1, 1'b1);
        chk("csum_bad_byte", 32'(stream_q[5]), 32'h0E);
        send(0, -1, -1);
        settle();
        expect_err("csum_bad");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes them into the instruction-memory write port at consecutive word addresses and holds the core in reset until a complete image has been loaded. It is the runtime replacement for the static instruction memory image: the loader writes the memory, and the core's fetch path reads it.

## Interface

Parameters:
- ADDR_W, 8, byte-address width of the instruction-memory write port; matches the fetch address width.
- MAX_WORDS, 64, largest accepted image in words; MAX_WORDS*4 must not exceed 2^ADDR_W.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored while busy.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a transfer happens when in_valid && in_ready at a rising edge.
- wr_en  output  1  one-cycle instruction-memory write strobe.
- wr_addr  output  ADDR_W  byte address, always word-aligned (bits [1:0] = 0).
- wr_data  output  32  assembled word.
- cpu_rst  output  1  active-high core reset; drives the core's rst.
- busy  output  1  load in progress.
- done  output  1  image loaded; core released.
- err  output  1  load aborted; core held in reset.

## Operation

- Stream format: one count byte N, followed by 4N payload bytes, least-significant byte of each word first.
- States and transitions:
  - IDLE → COUNT on start.
  - COUNT → LOAD when the count byte is accepted and 1 ≤ N ≤ MAX_WORDS. N=0 or N>MAX_WORDS → ERR.
  - LOAD → FLUSH after the 4N-th byte is accepted.
  - FLUSH → DONE (or CHECK, see Configuration).
  - DONE and ERR → COUNT on start.
- in_ready is 1 only in COUNT, LOAD and CHECK; it is 0 in IDLE, FLUSH, DONE and ERR.
- Byte lane counter (0..3): payload byte k of a word goes to bits [8k+7:8k]. The word is complete when lane 3 is accepted. The counter resets to 0 on every entry to LOAD.
- Word index runs 0..N-1. wr_addr = index*4, truncated to ADDR_W; no wrap is possible given the N check.
- in_valid low stalls the loader indefinitely with no timeout. Partial words are kept across stalls.
- busy = 1 in COUNT, LOAD, FLUSH and CHECK.
- cpu_rst = 0 only in DONE.
- done = 1 only in DONE.
- err = 1 only in ERR. err clears on start.
- start received while busy has no effect. start in DONE re-asserts cpu_rst on the next cycle, giving a full reload.
- Reset values: state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_rst=1, busy=0, done=0, err=0. Lane counter and word index are 0.
- A reset during a load abandons the load. Words already written remain in memory.

## Timing

- start at edge E: state is COUNT and in_ready=1 in the cycle after E.
- Lane-3 handshake at edge T: wr_en=1 in cycle T+1 only, with wr_addr and wr_data stable. in_ready stays 1, so the next word's bytes are accepted with no bubble.
- Last payload handshake at T: the final write occurs in cycle T+1 (FLUSH), and done=1 and cpu_rst=0 from cycle T+2. This guarantees every word is committed before the core leaves reset.
- Throughput: one byte per cycle sustained.

## Configuration

- IMEM_LOADER_CHECKSUM_EN defined:
  - A trailing checksum byte follows the payload. It equals the XOR of all 4N payload bytes; the count byte is excluded.
  - The FSM goes FLUSH → CHECK. CHECK accepts one byte, then goes to DONE on a match or ERR on a mismatch.
  - done and cpu_rst=0 arrive in the cycle after the checksum handshake.
- Macro undefined: the CHECK state and the XOR register are absent, there is no trailing byte, and FLUSH → DONE.

## Structure

- Package imem_loader_pkg holds:
  - the state enum (IDLE, COUNT, LOAD, FLUSH, CHECK, DONE, ERR);
  - the lane-counter width constant;
  - the WORD_BYTES=4 constant.
- Sub-module byte_packer holds the lane counter and 32-bit shift/assembly register. It takes a byte strobe and clear, and outputs the word plus a word_valid pulse.
- The top level holds the FSM, the word index, the write register and, optionally, the checksum.

## Test plan

- Reset, then N=2 with bytes 13 00 00 00 93 00 10 00 and in_valid continuously high:
  - wr_en at word 0: wr_addr=0x00, wr_data=0x00000013;
  - wr_en at word 1: wr_addr=0x04, wr_data=0x00100093;
  - done=1 and cpu_rst=0 two cycles after the last byte.
- Same image with in_valid toggling every other cycle: identical writes, no lost or duplicated bytes, word 1 unaffected by the stalls.
- N=0, and N=MAX_WORDS+1: err=1, cpu_rst=1, wr_en never asserted; a subsequent start and a valid N=1 image reach done.
- start pulsed during LOAD: no effect on the load. start in DONE: cpu_rst=1 next cycle, and a full reload writes from wr_addr=0.
- rst_n asserted mid-word: all outputs take reset values immediately. The next load's first word is assembled from lane 0.
- With IMEM_LOADER_CHECKSUM_EN, N=1 payload 01 02 04 08:
  - checksum 0x0F → done=1;
  - checksum 0x0E → err=1 and cpu_rst=1.
